// File: rtl/frame_sequencer_if.sv
// Bundle between the frame sequencer, the game control logic, the three drawers
// and the VGA adapter. master = sequencer side, slave = everything around it.
interface frame_sequencer_if #(
    parameter int COLOUR_W = 3,
    parameter int OVR_W    = 8
);
    // control from game logic
    logic                start;
    logic                frame_tick;
    logic                map_change;
    // drawer handshakes
    logic                map_enable,  hud_enable,  sprite_enable;
    logic                map_done,    hud_done,    sprite_done;
    // drawer pixel streams
    logic [8:0]          map_x,       hud_x,       sprite_x;
    logic [7:0]          map_y,       hud_y,       sprite_y;
    logic [COLOUR_W-1:0] map_colour,  hud_colour,  sprite_colour;
    logic                map_write,   hud_write,   sprite_write;
    // VGA write port and status
    logic [8:0]          vga_x;
    logic [7:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;
    logic                update_pulse;
    logic                busy;
    logic [OVR_W-1:0]    overrun_count;

    modport master (
        input  start, frame_tick, map_change,
        input  map_done, hud_done, sprite_done,
        input  map_x, hud_x, sprite_x,
        input  map_y, hud_y, sprite_y,
        input  map_colour, hud_colour, sprite_colour,
        input  map_write, hud_write, sprite_write,
        output map_enable, hud_enable, sprite_enable,
        output vga_x, vga_y, vga_colour, vga_write,
        output update_pulse, busy, overrun_count
    );

    modport slave (
        output start, frame_tick, map_change,
        output map_done, hud_done, sprite_done,
        output map_x, hud_x, sprite_x,
        output map_y, hud_y, sprite_y,
        output map_colour, hud_colour, sprite_colour,
        output map_write, hud_write, sprite_write,
        input  map_enable, hud_enable, sprite_enable,
        input  vga_x, vga_y, vga_colour, vga_write,
        input  update_pulse, busy, overrun_count
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame draw sequencer: game update pulse, then map (on request), HUD and
// sprite drawers in turn, with the active drawer's pixels muxed onto the VGA port.
module frame_sequencer #(
    parameter int COLOUR_W = 3,
    parameter int OVR_W    = 8
) (
    input logic                clock,
    input logic                resetn,
    frame_sequencer_if.master  bus
);
    localparam int NUM_DRW = 3;  // 0 = map, 1 = HUD, 2 = sprite

    typedef enum logic [3:0] {
        IDLE,
        WAIT_TICK,
        UPDATE,
        DRAW_MAP,
        GAP_MAP,
        DRAW_HUD,
        GAP_HUD,
        DRAW_SPRITE,
        GAP_SPRITE
    } state_t;

    typedef struct packed {
        logic [8:0]          x;
        logic [7:0]          y;
        logic [COLOUR_W-1:0] colour;
        logic                write;
    } pix_t;

    state_t                 state, state_nxt;
    logic                   redraw_map;
    logic                   pending;
    logic [OVR_W-1:0]       ovr_cnt;
    logic                   tick_in_frame;
    logic [NUM_DRW-1:0]     drw_en;
    pix_t [NUM_DRW-1:0]     drw_pix;
    pix_t                   vga_pix;

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (bus.start)                    state_nxt = WAIT_TICK;
            WAIT_TICK:   if (bus.frame_tick || pending)    state_nxt = UPDATE;
            UPDATE:      state_nxt = redraw_map ? DRAW_MAP : DRAW_HUD;
            DRAW_MAP:    if (bus.map_done)                 state_nxt = GAP_MAP;
            GAP_MAP:     state_nxt = DRAW_HUD;
            DRAW_HUD:    if (bus.hud_done)                 state_nxt = GAP_HUD;
            GAP_HUD:     state_nxt = DRAW_SPRITE;
            DRAW_SPRITE: if (bus.sprite_done)              state_nxt = GAP_SPRITE;
            GAP_SPRITE:  state_nxt = WAIT_TICK;
            default:     state_nxt = IDLE;
        endcase
    end

    // Ticks only count against the frame budget once a frame is in flight;
    // ticks in IDLE (including one alongside start) are dropped.
    assign tick_in_frame = bus.frame_tick && (state != IDLE) && (state != WAIT_TICK);

    // ---------------- redraw / pending / overrun flags ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            redraw_map <= 1'b1;
            pending    <= 1'b0;
            ovr_cnt    <= '0;
        end else begin
            // a new request in the cycle the map stage is entered must survive
            if (bus.map_change)                      redraw_map <= 1'b1;
            else if (state == UPDATE && redraw_map)  redraw_map <= 1'b0;

            if (state == WAIT_TICK) begin
                pending <= 1'b0;
            end else if (tick_in_frame) begin
                if (!pending)            pending <= 1'b1;
                else if (ovr_cnt != '1)  ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end

    // ---------------- Moore outputs ----------------
    assign drw_en[0] = (state == DRAW_MAP);
    assign drw_en[1] = (state == DRAW_HUD);
    assign drw_en[2] = (state == DRAW_SPRITE);

    assign bus.map_enable    = drw_en[0];
    assign bus.hud_enable    = drw_en[1];
    assign bus.sprite_enable = drw_en[2];
    assign bus.update_pulse  = (state == UPDATE);
    assign bus.busy          = (state != IDLE) && (state != WAIT_TICK);
    assign bus.overrun_count = ovr_cnt;

    // ---------------- pixel mux ----------------
    assign drw_pix[0] = {bus.map_x,    bus.map_y,    bus.map_colour,    bus.map_write};
    assign drw_pix[1] = {bus.hud_x,    bus.hud_y,    bus.hud_colour,    bus.hud_write};
    assign drw_pix[2] = {bus.sprite_x, bus.sprite_y, bus.sprite_colour, bus.sprite_write};

    // drw_en is one-hot or zero, so the port idles at all-zero between stages
    always_comb begin
        vga_pix = '0;
        for (int i = 0; i < NUM_DRW; i++) begin
            if (drw_en[i]) vga_pix = drw_pix[i];
        end
    end

    assign bus.vga_x      = vga_pix.x;
    assign bus.vga_y      = vga_pix.y;
    assign bus.vga_colour = vga_pix.colour;
    assign bus.vga_write  = vga_pix.write;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed + randomized bench for frame_sequencer; expected per-cycle outputs
// come from a frame timeline built from drawer latencies.
module tb_frame_sequencer;
    localparam int COLOUR_W = 3;
    localparam int OVR_W    = 8;

    localparam int ST_IDLE = 0, ST_UPD = 1, ST_GAP = 2, ST_MAP = 3, ST_HUD = 4, ST_SPR = 5;

    typedef struct packed {
        logic                upd, men, hen, sen, busy, wr;
        logic [8:0]          x;
        logic [7:0]          y;
        logic [COLOUR_W-1:0] c;
    } obs_t;

    logic clock;
    logic resetn;

    frame_sequencer_if #(.COLOUR_W(COLOUR_W), .OVR_W(OVR_W)) bus ();

    frame_sequencer #(.COLOUR_W(COLOUR_W), .OVR_W(OVR_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clock = ~clock;

    // drawer models: done comes dly cycles after enable rises, held while enabled
    int dly_m, dly_h, dly_s;
    int cnt_m, cnt_h, cnt_s;
    always @(posedge clock) begin
        cnt_m <= bus.map_enable    ? cnt_m + 1 : 0;
        cnt_h <= bus.hud_enable    ? cnt_h + 1 : 0;
        cnt_s <= bus.sprite_enable ? cnt_s + 1 : 0;
    end
    assign bus.map_done    = bus.map_enable    && (cnt_m >= dly_m);
    assign bus.hud_done    = bus.hud_enable    && (cnt_h >= dly_h);
    assign bus.sprite_done = bus.sprite_enable && (cnt_s >= dly_s);

    int               checks = 0;
    int               errors = 0;
    bit               redraw_m;
    bit               pending_m;
    logic [OVR_W-1:0] ovr_m;

    function automatic obs_t get_obs();
        obs_t o;
        o.upd  = bus.update_pulse;
        o.men  = bus.map_enable;
        o.hen  = bus.hud_enable;
        o.sen  = bus.sprite_enable;
        o.busy = bus.busy;
        o.wr   = bus.vga_write;
        o.x    = bus.vga_x;
        o.y    = bus.vga_y;
        o.c    = bus.vga_colour;
        return o;
    endfunction

    function automatic obs_t exp_of(input int st);
        obs_t e = '0;
        case (st)
            ST_UPD: begin e.upd = 1; e.busy = 1; end
            ST_GAP: e.busy = 1;
            ST_MAP: begin
                e.men = 1; e.busy = 1; e.wr = bus.map_write;
                e.x = bus.map_x; e.y = bus.map_y; e.c = bus.map_colour;
            end
            ST_HUD: begin
                e.hen = 1; e.busy = 1; e.wr = bus.hud_write;
                e.x = bus.hud_x; e.y = bus.hud_y; e.c = bus.hud_colour;
            end
            ST_SPR: begin
                e.sen = 1; e.busy = 1; e.wr = bus.sprite_write;
                e.x = bus.sprite_x; e.y = bus.sprite_y; e.c = bus.sprite_colour;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // compare now, without advancing time
    task automatic chk_now(input int st, input string tag);
        obs_t o, e;
        o = get_obs();
        e = exp_of(st);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, o, e);
        end
    endtask

    // compare at the falling edge of the current cycle, then move to the next cycle
    task automatic chk(input int st, input string tag);
        @(negedge clock);
        chk_now(st, tag);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ovr(input string tag);
        checks++;
        assert (bus.overrun_count === ovr_m) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.overrun_count, ovr_m);
        end
    endtask

    task automatic model_busy_tick();
        if (pending_m) begin
            if (ovr_m != '1) ovr_m++;
        end else begin
            pending_m = 1;
        end
    endtask

    // One frame starting from its WAIT_TICK cycle. nt extra ticks land on even
    // HUD cycles; mc_hud / mc_upd pulse map_change in HUD cycle 0 / UPDATE.
    task automatic run_frame(input bit tick, input int dm, input int dh, input int ds,
                             input int nt, input bit mc_hud, input bit mc_upd);
        bit do_map;
        int k;
        dly_m = dm; dly_h = dh; dly_s = ds;
        bus.frame_tick = tick;
        chk(ST_IDLE, "wait_tick");
        bus.frame_tick = 0;
        pending_m = 0;
        do_map = redraw_m;
        redraw_m = mc_upd;
        bus.map_change = mc_upd;
        chk(ST_UPD, "update");
        bus.map_change = 0;
        if (do_map) begin
            for (int i = 0; i <= dm; i++) chk(ST_MAP, "draw_map");
            chk(ST_GAP, "gap_map");
        end
        k = 0;
        for (int i = 0; i <= dh; i++) begin
            if (mc_hud && i == 0) begin bus.map_change = 1; redraw_m = 1; end
            if (k < nt && (i % 2) == 0) begin bus.frame_tick = 1; k++; model_busy_tick(); end
            chk(ST_HUD, "draw_hud");
            bus.frame_tick = 0;
            bus.map_change = 0;
        end
        chk(ST_GAP, "gap_hud");
        for (int i = 0; i <= ds; i++) chk(ST_SPR, "draw_sprite");
        chk(ST_GAP, "gap_sprite");
        chk_ovr("overrun_count");
    endtask

    task automatic set_spec_patterns();
        bus.map_x = 9'h00A;    bus.map_y = 8'h05;    bus.map_colour = 3'd1;    bus.map_write = 1;
        bus.hud_x = 9'h01F;    bus.hud_y = 8'h2A;    bus.hud_colour = 3'd2;    bus.hud_write = 1;
        bus.sprite_x = 9'h100; bus.sprite_y = 8'h7F; bus.sprite_colour = 3'd5; bus.sprite_write = 1;
    endtask

    task automatic set_rand_patterns();
        bus.map_x = 9'($urandom);    bus.map_y = 8'($urandom);    bus.map_colour = 3'($urandom);
        bus.hud_x = 9'($urandom);    bus.hud_y = 8'($urandom);    bus.hud_colour = 3'($urandom);
        bus.sprite_x = 9'($urandom); bus.sprite_y = 8'($urandom); bus.sprite_colour = 3'($urandom);
        bus.map_write = 1'($urandom); bus.hud_write = 1'($urandom); bus.sprite_write = 1'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        clock = 0;
        resetn = 0;
        bus.start = 0; bus.frame_tick = 0; bus.map_change = 0;
        dly_m = 3; dly_h = 3; dly_s = 3;
        cnt_m = 0; cnt_h = 0; cnt_s = 0;
        redraw_m = 1; pending_m = 0; ovr_m = '0;
        set_spec_patterns();

        // reset state
        chk(ST_IDLE, "reset");
        chk_ovr("reset_ovr");
        resetn = 1;

        // IDLE ignores ticks; start+tick together leaves nothing pending
        bus.frame_tick = 1;
        chk(ST_IDLE, "idle_tick");
        bus.start = 1;
        chk(ST_IDLE, "start_with_tick");
        bus.start = 0; bus.frame_tick = 0;
        repeat (3) chk(ST_IDLE, "wait_no_pending");

        // first frame always draws the map; done 3 cycles after each enable
        run_frame(1, 3, 3, 3, 0, 0, 0);
        // no map_change: map skipped
        run_frame(1, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0, 0, 0);
        // map_change during HUD
        run_frame(1, 2, 2, 1, 0, 1, 0);
        // map redrawn; map_change on map-entry cycle
        run_frame(1, 1, 0, 0, 0, 0, 1);
        // map redrawn again
        run_frame(1, 0, 1, 0, 0, 0, 0);

        // three ticks in a long HUD: one pending + two overruns; next frame back-to-back
        run_frame(1, 0, 20, 2, 3, 0, 0);
        run_frame(0, 0, 1, 1, 0, 0, 0);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            set_rand_patterns();
            run_frame(1, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      0, 1'($urandom_range(0, 1)), 0);
        end

        // overrun saturation
        set_spec_patterns();
        run_frame(1, 1, 604, 0, 301, 0, 0);
        run_frame(0, 1, 0, 0, 0, 0, 0);

        // asynchronous reset in the middle of a sprite draw
        dly_m = 2; dly_h = 2; dly_s = 12;
        bus.frame_tick = 1;
        @(posedge clock); #1;
        bus.frame_tick = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (bus.sprite_enable) found = 1;
            else begin @(posedge clock); #1; end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL sprite_reach observed=%0d expected=1", found);
        end
        resetn = 0;
        #1;
        redraw_m = 1; pending_m = 0; ovr_m = '0;
        chk_now(ST_IDLE, "async_reset");
        chk_ovr("async_reset_ovr");
        @(posedge clock); #1;
        resetn = 1;
        bus.frame_tick = 1;
        chk(ST_IDLE, "post_reset_tick");
        bus.frame_tick = 0;
        repeat (2) chk(ST_IDLE, "post_reset_idle");
        bus.start = 1;
        chk(ST_IDLE, "restart");
        bus.start = 0;
        run_frame(1, 1, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame draw sequencer between the game control logic and the VGA adapter. Each frame tick, it pulses a game-state update, then runs the map, HUD and sprite drawers in turn. A drawer runs only while its enable is held high and reports back on its done line. The sequencer also multiplexes the active drawer's pixel stream (x, y, colour, write) onto the single VGA write port. The map drawer runs only when a redraw has been requested, because redrawing it every frame would overrun the frame budget.

## Interface
- COLOUR_W, 3, colour bits per pixel on every pixel port
- OVR_W, 8, width of the saturating overrun counter
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE
- frame_tick  in  1  one-cycle pulse per display frame (60 Hz)
- map_change  in  1  one-cycle pulse; request map redraw on next frame
- map_done / hud_done / sprite_done  in  1 each  drawer finished; held high while its enable stays high
- map_x / hud_x / sprite_x  in  9 each  drawer pixel x
- map_y / hud_y / sprite_y  in  8 each  drawer pixel y
- map_colour / hud_colour / sprite_colour  in  COLOUR_W each  drawer pixel colour
- map_write / hud_write / sprite_write  in  1 each  drawer pixel write strobe
- map_enable / hud_enable / sprite_enable  out  1 each  run the corresponding drawer
- update_pulse  out  1  one-cycle pulse; game logic advances one step
- vga_x  out  9  muxed pixel x
- vga_y  out  8  muxed pixel y
- vga_colour  out  COLOUR_W  muxed colour
- vga_write  out  1  muxed write strobe
- busy  out  1  high in every state except IDLE and WAIT_TICK
- overrun_count  out  OVR_W  saturating count of dropped frame ticks

## Operation
- States: IDLE, WAIT_TICK, UPDATE, DRAW_MAP, GAP_MAP, DRAW_HUD, GAP_HUD, DRAW_SPRITE, GAP_SPRITE.
- IDLE: start=1 -> WAIT_TICK. frame_tick and map_change still update their flags as listed below.
- WAIT_TICK: frame_tick=1 or pending=1 -> UPDATE, and pending clears.
- UPDATE (exactly 1 cycle, update_pulse=1): redraw_map=1 -> DRAW_MAP, else -> DRAW_HUD.
- DRAW_MAP: map_enable=1. redraw_map clears on entry. map_done=1 -> GAP_MAP.
- GAP_MAP: all enables 0 for 1 cycle, so the drawer clears its counters and done flag. Then -> DRAW_HUD.
- DRAW_HUD / GAP_HUD: same pattern as the map stage, then -> DRAW_SPRITE.
- DRAW_SPRITE / GAP_SPRITE: same pattern, then -> WAIT_TICK.
- redraw_map flag:
  - Set to 1 at reset; the first frame always draws the map.
  - Set by map_change in any state.
  - If a set and the clear on DRAW_MAP entry happen in the same cycle, set wins.
- pending flag:
  - Set by frame_tick in any state other than IDLE and WAIT_TICK.
  - If pending is already 1 when such a tick arrives, overrun_count increments instead, saturating at 2^OVR_W−1.
- Pixel mux:
  - In DRAW_X state, vga_x, vga_y, vga_colour and vga_write follow drawer X combinationally.
  - In all other states, vga_write=0 and vga_x/vga_y/vga_colour=0.
- Enables and busy are decoded from the registered state (Moore outputs); there is no combinational path from done to enable.
- Nothing aborts a drawer mid-draw. The VGA pixel stream of a stage is never truncated.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, redraw_map=1, pending=0, overrun_count=0.
  - All enables, update_pulse, vga_write and busy go to 0; vga_x/vga_y/vga_colour go to 0.
  - The same applies when resetn asserts mid-draw: enables drop immediately.
- Tick at edge n while in WAIT_TICK: UPDATE in cycle n+1, then first DRAW_* enable high in n+2.
- done sampled high at edge n: enable low from n+1 (GAP state), next stage's enable high from n+2.
- Minimum frame cost: 1 (UPDATE) + 2 (HUD with done on first cycle) + 2 (sprite) = 5 cycles.
- A frame_tick and a start in the same IDLE cycle: only start is acted on; the tick is dropped and does not set pending.
- A tick arriving in GAP_SPRITE sets pending; the next frame starts 2 cycles after leaving GAP_SPRITE (WAIT_TICK, then UPDATE).

## Test plan
- Reset then start, tick, each done raised 3 cycles after its enable -> sequence UPDATE, map, HUD, sprite.
  - Exactly one cycle with all enables low between stages.
  - busy falls when WAIT_TICK is re-entered.
- Second tick with no map_change -> map_enable never asserts; hud_enable is high 2 cycles after the tick edge.
- map_change pulsed during DRAW_HUD -> next frame includes DRAW_MAP. map_change in the same cycle as DRAW_MAP entry -> the following frame redraws the map again.
- Pixel mux: distinct per-drawer x/y/colour patterns (map 0x0A/0x05/1, HUD 0x1F/0x2A/2, sprite 0x100/0x7F/5), with each write strobe held high.
  - vga_* matches only the active drawer.
  - vga_write=0 in GAP, UPDATE and WAIT_TICK.
- Overrun: three ticks during one long HUD draw -> pending=1, overrun_count=2; the next frame starts immediately after GAP_SPRITE. Forcing 300 overruns -> overrun_count=255.
- resetn pulsed low mid-DRAW_SPRITE -> outputs zero asynchronously; the next tick is ignored until start.
